// File: rtl/ls_sequencer_if.sv
// Handshake/bus bundle for ls_sequencer. The master side is the control unit
// and FIFOs/MXU stimulus; the slave side is the sequencer itself.
`ifndef LOG_ALLOWED_PRECISIONS
`define LOG_ALLOWED_PRECISIONS 2
`endif

interface ls_sequencer_if #(
  parameter int ROWS            = 4,
  parameter int COLUMNS         = 4,
  parameter int address_leng_wm = 32
);
  localparam int CW = $clog2(COLUMNS) + 1;
  localparam int WW = $clog2(ROWS*COLUMNS) + 1;

  logic                                start;
  logic [`LOG_ALLOWED_PRECISIONS-1:0]  data_precision;
  logic [address_leng_wm-1:0]          wm_start_addr;
  logic                                infifo_empty;
  logic                                outfifo_full;
  logic                                mxu_done;

  logic                                busy;
  logic                                done;
  logic                                enable_load_array;
  logic                                ld_max_cnt;
  logic                                ld_max_cnt_weight;
  logic                                ld_weight_page_cnt;
  logic [CW-1:0]                       max_cnt_from_cu;
  logic [WW-1:0]                       max_cnt_weight_from_cu;
  logic [address_leng_wm-1:0]          start_value_wm;
  logic                                enable_cnt_weight;
  logic [ROWS*COLUMNS-1:0]             read_weight_memory;
  logic                                infifo_read;
  logic [COLUMNS:0]                    enable_load_activation_data;
  logic                                mxu_start;
  logic                                outfifo_write;
  logic [COLUMNS:0]                    enable_store_activation_data;
  logic                                enable_cnt;

  modport master (
    output start, data_precision, wm_start_addr, infifo_empty, outfifo_full, mxu_done,
    input  busy, done, enable_load_array, ld_max_cnt, ld_max_cnt_weight, ld_weight_page_cnt,
           max_cnt_from_cu, max_cnt_weight_from_cu, start_value_wm, enable_cnt_weight,
           read_weight_memory, infifo_read, enable_load_activation_data, mxu_start,
           outfifo_write, enable_store_activation_data, enable_cnt
  );

  modport slave (
    input  start, data_precision, wm_start_addr, infifo_empty, outfifo_full, mxu_done,
    output busy, done, enable_load_array, ld_max_cnt, ld_max_cnt_weight, ld_weight_page_cnt,
           max_cnt_from_cu, max_cnt_weight_from_cu, start_value_wm, enable_cnt_weight,
           read_weight_memory, infifo_read, enable_load_activation_data, mxu_start,
           outfifo_write, enable_store_activation_data, enable_cnt
  );
endinterface

// File: rtl/ls_sequencer.sv
// Tile sequencer for the MXU: config, weight fetch, activation load, compute
// handshake and result store. Every output is driven directly by a flop.
`ifndef LOG_ALLOWED_PRECISIONS
`define LOG_ALLOWED_PRECISIONS 2
`endif

module ls_sequencer #(
  parameter int ROWS            = 4,
  parameter int COLUMNS         = 4,
  parameter int WM_LATENCY      = 2,
  parameter int address_leng_wm = 32
) (
  input logic           clk,
  input logic           reset,
  ls_sequencer_if.slave bus
);
  localparam int CW = $clog2(COLUMNS) + 1;
  localparam int WW = $clog2(ROWS*COLUMNS) + 1;
  localparam int RW = ROWS*COLUMNS;
  localparam int AW = address_leng_wm;

  typedef enum logic [2:0] {IDLE, CFG, LOAD_W, DRAIN_W, LOAD_A, COMPUTE, STORE, FIN} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         n_q, n_d, col_q, col_d;
  logic [WW-1:0]         w_q, w_d, wcnt_q, wcnt_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic                  ld_q, ld_d, ecw_q, ecw_d, rd_q, rd_d, mxs_q, mxs_d;
  logic                  wr_q, wr_d, done_q, done_d, busy_q, busy_d;
  logic [COLUMNS:0]      lda_q, lda_d, sta_q, sta_d;
  logic [CW-1:0]         n_sel;
  logic [WW-1:0]         w_sel;
  logic [RW-1:0]         rw_in;
  logic [WM_LATENCY:1][RW-1:0] rw_pipe_q;

  // Wider precisions pack fewer columns; at least one column stays active.
  always_comb begin
    n_sel = CW'(COLUMNS >> bus.data_precision);
    if (n_sel == '0) n_sel = CW'(1);
    w_sel = WW'(ROWS * int'(n_sel));
  end

  // Weight capture strobe trails the address-counter enable by the memory latency.
  assign rw_in = ecw_q ? (RW'(1) << wcnt_q) : '0;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    w_d     = w_q;
    addr_d  = addr_q;
    wcnt_d  = wcnt_q;
    col_d   = col_q;
    ld_d    = 1'b0;
    ecw_d   = 1'b0;
    rd_d    = 1'b0;
    lda_d   = '0;
    mxs_d   = 1'b0;
    wr_d    = 1'b0;
    sta_d   = '0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: if (bus.start) begin
        state_d = CFG;
        n_d     = n_sel;
        w_d     = w_sel;
        addr_d  = bus.wm_start_addr;
        ld_d    = 1'b1;
      end
      CFG: begin
        state_d = LOAD_W;
        wcnt_d  = '0;
        ecw_d   = 1'b1;
      end
      LOAD_W: if (wcnt_q == w_q - WW'(1)) state_d = DRAIN_W;
        else begin
          wcnt_d = wcnt_q + WW'(1);
          ecw_d  = 1'b1;
        end
      DRAIN_W: if (rw_pipe_q[WM_LATENCY][w_q - WW'(1)]) begin
        state_d = LOAD_A;
        col_d   = '0;
      end
      // col_q == n_q means every column strobe has already been issued.
      LOAD_A: if (col_q == n_q) begin
        state_d = COMPUTE;
        mxs_d   = 1'b1;
      end else if (!bus.infifo_empty) begin
        rd_d  = 1'b1;
        lda_d = (COLUMNS+1)'(1) << col_q;
        col_d = col_q + CW'(1);
      end
      COMPUTE: if (bus.mxu_done) begin
        state_d = STORE;
        col_d   = '0;
      end
      STORE: if (col_q == n_q) begin
        state_d = FIN;
        done_d  = 1'b1;
      end else if (!bus.outfifo_full) begin
        wr_d  = 1'b1;
        sta_d = (COLUMNS+1)'(1) << col_q;
        col_d = col_q + CW'(1);
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      n_q       <= '0;
      w_q       <= '0;
      addr_q    <= '0;
      wcnt_q    <= '0;
      col_q     <= '0;
      ld_q      <= 1'b0;
      ecw_q     <= 1'b0;
      rd_q      <= 1'b0;
      lda_q     <= '0;
      mxs_q     <= 1'b0;
      wr_q      <= 1'b0;
      sta_q     <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      rw_pipe_q <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      w_q       <= w_d;
      addr_q    <= addr_d;
      wcnt_q    <= wcnt_d;
      col_q     <= col_d;
      ld_q      <= ld_d;
      ecw_q     <= ecw_d;
      rd_q      <= rd_d;
      lda_q     <= lda_d;
      mxs_q     <= mxs_d;
      wr_q      <= wr_d;
      sta_q     <= sta_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      rw_pipe_q[1] <= rw_in;
      for (int i = 2; i <= WM_LATENCY; i++) rw_pipe_q[i] <= rw_pipe_q[i-1];
    end
  end

  assign bus.busy                         = busy_q;
  assign bus.enable_load_array            = busy_q;
  assign bus.done                         = done_q;
  assign bus.ld_max_cnt                   = ld_q;
  assign bus.ld_max_cnt_weight            = ld_q;
  assign bus.ld_weight_page_cnt           = ld_q;
  assign bus.max_cnt_from_cu              = n_q;
  assign bus.max_cnt_weight_from_cu       = w_q;
  assign bus.start_value_wm               = addr_q;
  assign bus.enable_cnt_weight            = ecw_q;
  assign bus.read_weight_memory           = rw_pipe_q[WM_LATENCY];
  assign bus.infifo_read                  = rd_q;
  assign bus.enable_load_activation_data  = lda_q;
  assign bus.mxu_start                    = mxs_q;
  assign bus.outfifo_write                = wr_q;
  assign bus.enable_cnt                   = wr_q;
  assign bus.enable_store_activation_data = sta_q;
endmodule

// File: tb/tb_ls_sequencer.sv
// Directed bench for ls_sequencer: per-tile strobe logging with hand-computed
// expectations for counts, ordering, weight latency, stalls and reset.
module tb_ls_sequencer;
  localparam int ROWS = 4, COLUMNS = 4, WML = 2, AW = 32;
  localparam int RW = ROWS*COLUMNS;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ls_sequencer_if #(.ROWS(ROWS), .COLUMNS(COLUMNS), .address_leng_wm(AW)) bus();
  ls_sequencer #(.ROWS(ROWS), .COLUMNS(COLUMNS), .WM_LATENCY(WML), .address_leng_wm(AW))
    dut (.clk(clk), .reset(reset), .bus(bus));

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Strobe log, sampled just after each rising edge.
  int cyc = 0;
  int ecw_n = 0, rw_n = 0, rd_n = 0, wr_n = 0, done_n = 0, mxs_n = 0;
  int bad_n = 0, remp_n = 0, wfull_n = 0;
  int ecw_t[256], rw_t[256], lda_c[256], sta_c[256];
  logic [RW-1:0] rw_v[256];

  always @(posedge clk) begin
    #1;
    cyc++;
    if (bus.enable_cnt_weight) begin
      if (ecw_n < 256) ecw_t[ecw_n] = cyc;
      ecw_n++;
    end
    if (bus.read_weight_memory != '0) begin
      if (rw_n < 256) begin rw_t[rw_n] = cyc; rw_v[rw_n] = bus.read_weight_memory; end
      rw_n++;
    end
    if (bus.infifo_read) begin
      if ($countones(bus.enable_load_activation_data) != 1) bad_n++;
      if (rd_n < 256) lda_c[rd_n] = $clog2(bus.enable_load_activation_data);
      if (bus.infifo_empty) remp_n++;
      rd_n++;
    end else if (bus.enable_load_activation_data != '0) bad_n++;
    if (bus.outfifo_write) begin
      if ($countones(bus.enable_store_activation_data) != 1) bad_n++;
      if (wr_n < 256) sta_c[wr_n] = $clog2(bus.enable_store_activation_data);
      if (bus.outfifo_full) wfull_n++;
      wr_n++;
    end else if (bus.enable_store_activation_data != '0) bad_n++;
    if (bus.enable_load_activation_data[COLUMNS] || bus.enable_store_activation_data[COLUMNS]) bad_n++;
    if (bus.outfifo_write != bus.enable_cnt) bad_n++;
    if (bus.busy != bus.enable_load_array) bad_n++;
    if (bus.done) done_n++;
    if (bus.mxu_start) mxs_n++;
  end

  int b_ecw, b_rw, b_rd, b_wr, b_done, b_mxs, b_bad, b_remp, b_wfull;
  task automatic snap();
    b_ecw = ecw_n; b_rw = rw_n; b_rd = rd_n; b_wr = wr_n; b_done = done_n;
    b_mxs = mxs_n; b_bad = bad_n; b_remp = remp_n; b_wfull = wfull_n;
  endtask

  function automatic logic any_out();
    return bus.busy | bus.done | bus.enable_load_array | bus.ld_max_cnt | bus.ld_max_cnt_weight |
           bus.ld_weight_page_cnt | (|bus.max_cnt_from_cu) | (|bus.max_cnt_weight_from_cu) |
           (|bus.start_value_wm) | bus.enable_cnt_weight | (|bus.read_weight_memory) |
           bus.infifo_read | (|bus.enable_load_activation_data) | bus.mxu_start |
           bus.outfifo_write | (|bus.enable_store_activation_data) | bus.enable_cnt;
  endfunction

  function automatic logic sig(input int sel);
    case (sel)
      0:       return bus.mxu_start;
      1:       return bus.done;
      2:       return bus.enable_cnt_weight;
      3:       return bus.infifo_read;
      default: return bus.outfifo_write & bus.enable_store_activation_data[1];
    endcase
  endfunction

  task automatic wait_sig(input string tag, input int sel);
    int t = 0;
    while (!sig(sel) && t < 400) begin @(negedge clk); t++; end
    chk(tag, 64'(sig(sel)), 64'd1);
  endtask

  task automatic start_tile(input logic [1:0] prec, input logic [AW-1:0] addr);
    bus.start = 1'b1; bus.data_precision = prec; bus.wm_start_addr = addr;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Answers mxu_start with mxu_done a few cycles later; optionally pokes start in COMPUTE.
  task automatic pulse_mxu(input bit poke);
    wait_sig("mxs_seen", 0);
    if (poke) begin
      bus.start = 1'b1; bus.data_precision = 2'd0; bus.wm_start_addr = 32'h0000_1234;
      @(negedge clk);
      bus.start = 1'b0;
      chk("cmp_poke_n", 64'(bus.max_cnt_from_cu), 64'd2);
      chk("cmp_poke_addr", 64'(bus.start_value_wm), 64'h0000_0300);
    end
    repeat (4) @(negedge clk);
    bus.mxu_done = 1'b1;
    @(negedge clk);
    bus.mxu_done = 1'b0;
  endtask

  task automatic wait_done(input bit poke);
    wait_sig("done_seen", 1);
    if (poke) bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_busy", 64'(bus.busy), 64'd0);
  endtask

  task automatic verify(input string tag, input int n, input int w);
    logic [RW-1:0] e;
    chk({tag, "_ecw"},  64'(ecw_n - b_ecw),   64'(w));
    chk({tag, "_rw"},   64'(rw_n - b_rw),     64'(w));
    chk({tag, "_rd"},   64'(rd_n - b_rd),     64'(n));
    chk({tag, "_wr"},   64'(wr_n - b_wr),     64'(n));
    chk({tag, "_done"}, 64'(done_n - b_done), 64'd1);
    chk({tag, "_mxs"},  64'(mxs_n - b_mxs),   64'd1);
    chk({tag, "_bad"},  64'(bad_n - b_bad),   64'd0);
    chk({tag, "_remp"}, 64'(remp_n - b_remp), 64'd0);
    chk({tag, "_wful"}, 64'(wfull_n - b_wfull), 64'd0);
    for (int k = 0; k < w; k++) begin
      e = RW'(1) << k;
      chk($sformatf("%s_rwv%0d", tag, k), 64'(rw_v[b_rw+k]), 64'(e));
      chk($sformatf("%s_lat%0d", tag, k), 64'(rw_t[b_rw+k] - ecw_t[b_ecw+k]), 64'(WML));
      chk($sformatf("%s_ecwt%0d", tag, k), 64'(ecw_t[b_ecw+k] - ecw_t[b_ecw]), 64'(k));
    end
    for (int c = 0; c < n; c++) begin
      chk($sformatf("%s_ldc%0d", tag, c), 64'(lda_c[b_rd+c]), 64'(c));
      chk($sformatf("%s_stc%0d", tag, c), 64'(sta_c[b_wr+c]), 64'(c));
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r, d;
    bus.start = 1'b0; bus.data_precision = 2'd0; bus.wm_start_addr = '0;
    bus.infifo_empty = 1'b0; bus.outfifo_full = 1'b0; bus.mxu_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outs", 64'(any_out()), 64'd0);

    // INT64: N=1, W=4; start in the very first cycle after reset release.
    snap();
    reset = 1'b0;
    start_tile(2'd3, 32'hA5A5_0040);
    chk("cfg_ld",   64'(bus.ld_max_cnt), 64'd1);
    chk("cfg_ldw",  64'(bus.ld_max_cnt_weight), 64'd1);
    chk("cfg_ldp",  64'(bus.ld_weight_page_cnt), 64'd1);
    chk("cfg_n",    64'(bus.max_cnt_from_cu), 64'd1);
    chk("cfg_w",    64'(bus.max_cnt_weight_from_cu), 64'd4);
    chk("cfg_addr", 64'(bus.start_value_wm), 64'hA5A5_0040);
    chk("cfg_busy", 64'(bus.busy), 64'd1);
    @(negedge clk);
    chk("cfg_1cyc", 64'(bus.ld_max_cnt), 64'd0);
    pulse_mxu(1'b0);
    wait_done(1'b0);
    verify("i64", 1, 4);

    // INT8 with input FIFO empty for 3 cycles after the first load.
    snap();
    start_tile(2'd0, 32'h0000_0100);
    wait_sig("ld_seen", 3);
    bus.infifo_empty = 1'b1;
    r = rd_n;
    repeat (3) @(negedge clk);
    chk("emp_noread", 64'(rd_n - r), 64'd0);
    chk("emp_busy",   64'(bus.busy), 64'd1);
    bus.infifo_empty = 1'b0;
    pulse_mxu(1'b0);
    wait_done(1'b0);
    verify("i8e", 4, 16);

    // INT8 with output FIFO full while column 2 is pending.
    snap();
    start_tile(2'd0, 32'h0000_0200);
    pulse_mxu(1'b0);
    wait_sig("st1_seen", 4);
    bus.outfifo_full = 1'b1;
    r = wr_n;
    repeat (3) @(negedge clk);
    chk("full_nowr",  64'(wr_n - r), 64'd0);
    chk("full_ndone", 64'(done_n - b_done), 64'd0);
    bus.outfifo_full = 1'b0;
    wait_done(1'b0);
    verify("i8f", 4, 16);

    // INT16 with start pokes in LOAD_W, COMPUTE and FIN; stray mxu_done in LOAD_W.
    snap();
    start_tile(2'd1, 32'h0000_0300);
    wait_sig("lw_seen", 2);
    bus.start = 1'b1; bus.data_precision = 2'd0; bus.mxu_done = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.mxu_done = 1'b0;
    chk("lw_poke_w", 64'(bus.max_cnt_weight_from_cu), 64'd8);
    pulse_mxu(1'b1);
    wait_done(1'b1);
    verify("i16p", 2, 8);

    // Reset during COMPUTE abandons the tile; a later mxu_done does nothing.
    start_tile(2'd1, 32'h0000_0400);
    wait_sig("rc_mxs", 0);
    reset = 1'b1;
    d = done_n;
    @(negedge clk);
    chk("rc_outs", 64'(any_out()), 64'd0);
    chk("rc_busy", 64'(bus.busy), 64'd0);
    reset = 1'b0;
    r = wr_n;
    repeat (2) @(negedge clk);
    bus.mxu_done = 1'b1;
    @(negedge clk);
    bus.mxu_done = 1'b0;
    repeat (4) @(negedge clk);
    chk("rc_nodone", 64'(done_n - d), 64'd0);
    chk("rc_nowr",   64'(wr_n - r), 64'd0);
    chk("rc_idle",   64'(bus.busy), 64'd0);
    snap();
    start_tile(2'd2, 32'h0000_0500);
    chk("rc_cfg_n", 64'(bus.max_cnt_from_cu), 64'd1);
    pulse_mxu(1'b0);
    wait_done(1'b0);
    verify("i32r", 1, 4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
